// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch defaults, fetch state, opcode/funct constants.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT     = 32'h0000_0000;
  localparam logic [XLEN-1:0] HALT_WORD_DEFAULT    = 32'hFFFF_FFFF;
  localparam int unsigned     DRAIN_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FUNCT_JR   = 6'h08;

  // True for j, jal and jr: the instructions the ID stage redirects on.
  function automatic logic is_jump(input logic [XLEN-1:0] instr);
    return (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL) ||
           ((instr[31:26] == OP_SPECIAL) && (instr[5:0] == FUNCT_JR));
  endfunction

  // True for the conditional branches resolved in EX.
  function automatic logic is_branch(input logic [XLEN-1:0] instr);
    return (instr[31:26] == OP_BEQ) || (instr[31:26] == OP_BNE);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch: instruction, PC+4 and valid, with hold and flush.
module if_id_reg
  import mips_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            i_hold,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc_plus4,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_valid
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;

  // Flush (bubble) wins over hold; otherwise load a real instruction.
  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_instr    <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (!i_hold) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, redirect mux, stall handling and halt/drain FSM.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        id_jump,
  input  logic        id_jr,
  input  logic [25:0] id_target,
  input  logic [31:0] id_jr_addr,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        control_mux,
  output logic        halted,
  output logic        done
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      w_pc_nxt;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_jump_addr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_hold;
  logic             w_flush;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_jump_addr = {if_id_pc_plus4[31:28], id_target, 2'b00};

  // Next-state, next-PC and IF/ID control; the default is to hold everything.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_hold      = 1'b1;
    w_flush     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (ex_branch_taken) begin
          w_pc_nxt = ex_branch_target;
          w_flush  = 1'b1;
        end else if (stall) begin
          w_hold = 1'b1;
        end else if (id_jump && if_id_valid) begin
          w_pc_nxt = id_jr ? id_jr_addr : w_jump_addr;
          w_flush  = 1'b1;
        end else if (imem_data == HALT_WORD) begin
          // Halt word is never latched; PC stays on it while the pipe drains.
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
          w_flush     = 1'b1;
        end else begin
          w_pc_nxt = w_pc_plus4;
          w_hold   = 1'b0;
        end
      end
      ST_DRAIN: begin
        w_flush = 1'b1;
        if (ex_branch_taken) begin
          // Halt was fetched on a wrong path: resume at the branch target.
          w_state_nxt = ST_RUN;
          w_pc_nxt    = ex_branch_target;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_hold = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State, PC and drain counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  if_id_reg u_if_id_reg (
    .clock      (clock),
    .reset      (reset),
    .i_hold     (w_hold),
    .i_flush    (w_flush),
    .i_instr    (imem_data),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (if_id_instr),
    .o_pc_plus4 (if_id_pc_plus4),
    .o_valid    (if_id_valid)
  );

  assign imem_addr   = r_pc;
  assign control_mux = if_id_valid & ~ex_branch_taken;
  assign halted      = (r_state != ST_RUN);
  assign done        = (r_state == ST_DONE);

endmodule
